// File: rtl/fifo_rd_pkg.sv
// Shared sizing constants and types for the FIFO read-side stream adapter.
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int XFER_CNT_W = 16;

  typedef logic [1:0] occ_t;

  // The credit rule keeps occ within 0..2, so plain 2-bit arithmetic cannot wrap.
  function automatic occ_t occ_next(input occ_t occ, input logic inc, input logic dec);
    return occ + occ_t'(inc) - occ_t'(dec);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry register skid buffer with 1-bit wrap-around pointers.
// rd_data always comes from registered storage.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DataSize = 3
) (
  input  logic                Rclk,
  input  logic                Rresetn,
  input  logic                wr_en,
  input  logic [DataSize-1:0] wr_data,
  input  logic                rd_en,
  output logic [DataSize-1:0] rd_data,
  output occ_t                occ
);

  logic [DataSize-1:0] mem_q [SKID_DEPTH];
  logic [DataSize-1:0] mem_d [SKID_DEPTH];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  occ_t                occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_next(occ_q, wr_en, rd_en);
  end

  always_ff @(posedge Rclk or negedge Rresetn) begin
    if (!Rresetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Converts the async FIFO Pop/empty/DataOut read port into a valid/ready stream.
// Optional transfer counter port XferCnt is enabled by RD_ADAPT_XFER_CNT_EN.
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DataSize = 3
) (
  input  logic                  Rclk,
  input  logic                  Rresetn,
  output logic                  Pop,
  input  logic                  empty,
  input  logic [DataSize-1:0]   DataOut,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DataSize-1:0]   m_data
`ifdef RD_ADAPT_XFER_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0] XferCnt
`endif
);

  logic       infl_q, infl_d;
  logic       hs;
  occ_t       occ;
  logic [2:0] credit;

  assign m_valid = (occ != '0);
  assign hs      = m_valid && m_ready;

  // Pop only when the word it fetches is guaranteed a slot two cycles from now.
  always_comb begin
    credit = {1'b0, occ} + {2'b00, infl_q} - {2'b00, hs};
    Pop    = Rresetn && !empty && (credit < 3'd2);
    infl_d = Pop;
  end

  always_ff @(posedge Rclk or negedge Rresetn) begin
    if (!Rresetn) begin
      infl_q <= 1'b0;
    end else begin
      infl_q <= infl_d;
    end
  end

  fifo_rd_skid_buf #(
    .DataSize(DataSize)
  ) u_skid (
    .Rclk   (Rclk),
    .Rresetn(Rresetn),
    .wr_en  (infl_q),
    .wr_data(DataOut),
    .rd_en  (hs),
    .rd_data(m_data),
    .occ    (occ)
  );

`ifdef RD_ADAPT_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(hs);
  end

  always_ff @(posedge Rclk or negedge Rresetn) begin
    if (!Rresetn) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign XferCnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural 1-cycle-latency FIFO model.
// Counter checks run only when RD_ADAPT_XFER_CNT_EN is defined.
module tb_fifo_rd_stream_adapter;

  logic        Rclk = 1'b0;
  logic        Rresetn;
  logic        Pop;
  logic        empty;
  logic [2:0]  DataOut = '0;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  m_data;
`ifdef RD_ADAPT_XFER_CNT_EN
  logic [15:0] XferCnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0]  fifo_mem [256];
  logic [31:0] fifo_wr_cnt = '0;
  logic [31:0] fifo_rd_idx = '0;
  logic        empty_force = 1'b0;
  logic [2:0]  exp_q [$];

  always #5 Rclk = ~Rclk;

  fifo_rd_stream_adapter #(.DataSize(3)) dut (
    .Rclk   (Rclk),
    .Rresetn(Rresetn),
    .Pop    (Pop),
    .empty  (empty),
    .DataOut(DataOut),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
`ifdef RD_ADAPT_XFER_CNT_EN
    ,
    .XferCnt(XferCnt)
`endif
  );

  // FIFO model: data appears on DataOut the cycle after Pop is sampled.
  assign empty = empty_force || (fifo_rd_idx == fifo_wr_cnt);

  always @(posedge Rclk) begin
    if (Pop) begin
      DataOut     <= fifo_mem[fifo_rd_idx[7:0]];
      fifo_rd_idx <= fifo_rd_idx + 1;
    end
  end

  task automatic tick();
    @(posedge Rclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] word);
    fifo_mem[fifo_wr_cnt[7:0]] = word;
    exp_q.push_back(word);
    fifo_wr_cnt = fifo_wr_cnt + 1;
  endtask

  task automatic drainCheck(input string tag, input bit toggle_empty);
    int expected_n;
    int got;
    expected_n = exp_q.size();
    got = 0;
    for (int c = 0; c < 24; c++) begin
      if (m_valid && m_ready) begin
        got++;
        if (exp_q.size() != 0) checkOutput(tag, 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (toggle_empty) empty_force = ~empty_force;
      tick();
    end
    empty_force = 1'b0;
    #1;
    checkOutput({tag, "_count"}, got, expected_n);
    checkOutput({tag, "_idle"}, 32'(m_valid), 0);
  endtask

  initial begin
    int pops;
    Rresetn = 1'b1;
    m_ready = 1'b0;

    // Reset while the FIFO already holds three words.
    applyStimulus(3'd5);
    applyStimulus(3'd6);
    applyStimulus(3'd7);
    #1 Rresetn = 1'b0;
    tick();
    tick();
    checkOutput("rst_pop", 32'(Pop), 0);
    checkOutput("rst_valid", 32'(m_valid), 0);
    checkOutput("rst_data", 32'(m_data), 0);
    checkOutput("rst_occ", 32'(dut.occ), 0);
`ifdef RD_ADAPT_XFER_CNT_EN
    checkOutput("rst_xfer", 32'(XferCnt), 0);
`endif
    Rresetn = 1'b1;
    #1;
    checkOutput("release_pop", 32'(Pop), 1);
    tick();
    checkOutput("release_t1_valid", 32'(m_valid), 0);
    tick();
    checkOutput("release_t2_valid", 32'(m_valid), 1);
    checkOutput("release_t2_data", 32'(m_data), 5);
    checkOutput("release_t2_pop", 32'(Pop), 0);
    m_ready = 1'b1;
    drainCheck("release_drain", 1'b0);

    // Full-throughput stream of 0..7 with m_ready held high.
    for (int i = 0; i < 8; i++) applyStimulus(3'(i));
    #1;
    checkOutput("stream_pop", 32'(Pop), 1);
    tick();
    checkOutput("stream_t1_valid", 32'(m_valid), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("stream_valid", 32'(m_valid), 1);
      checkOutput("stream_data", 32'(m_data), i);
      void'(exp_q.pop_front());
    end
    tick();
    checkOutput("stream_end_valid", 32'(m_valid), 0);
`ifdef RD_ADAPT_XFER_CNT_EN
    checkOutput("stream_xfer", 32'(XferCnt), 11);
`endif

    // Backpressure: five words available, consumer stalled.
    m_ready = 1'b0;
    applyStimulus(3'd3);
    applyStimulus(3'd1);
    applyStimulus(3'd4);
    applyStimulus(3'd6);
    applyStimulus(3'd5);
    #1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      pops += int'(Pop);
      tick();
    end
    checkOutput("bp_pops", pops, 2);
    checkOutput("bp_occ", 32'(dut.occ), 2);
    checkOutput("bp_valid", 32'(m_valid), 1);
    checkOutput("bp_data", 32'(m_data), 3);
    tick();
    checkOutput("bp_hold_data", 32'(m_data), 3);
    checkOutput("bp_hold_pop", 32'(Pop), 0);
    m_ready = 1'b1;
    drainCheck("bp_drain", 1'b0);

    // empty toggling every cycle.
    applyStimulus(3'd2);
    applyStimulus(3'd5);
    applyStimulus(3'd0);
    applyStimulus(3'd7);
    drainCheck("alt_empty", 1'b1);

    // Reset with a word held and another in flight.
    m_ready = 1'b0;
    applyStimulus(3'd1);
    applyStimulus(3'd2);
    applyStimulus(3'd3);
    #1;
    tick();
    tick();
    checkOutput("midrst_pre_valid", 32'(m_valid), 1);
    checkOutput("midrst_pre_infl", 32'(dut.infl_q), 1);
    Rresetn = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(m_valid), 0);
    checkOutput("midrst_occ", 32'(dut.occ), 0);
    checkOutput("midrst_pop", 32'(Pop), 0);
    checkOutput("midrst_data", 32'(m_data), 0);
    tick();
    tick();
    Rresetn = 1'b1;
    m_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(3'd3);
    drainCheck("midrst_drain", 1'b0);
`ifdef RD_ADAPT_XFER_CNT_EN
    checkOutput("midrst_xfer", 32'(XferCnt), 1);

    // 65537 handshakes wrap the counter back to 1.
    begin
      bit done;
      Rresetn = 1'b0;
      #1;
      tick();
      Rresetn = 1'b1;
      #1;
      checkOutput("wrap_start_xfer", 32'(XferCnt), 0);
      fifo_wr_cnt = fifo_wr_cnt + 32'd65537;
      done = 1'b0;
      for (int c = 0; c < 70000 && !done; c++) begin
        tick();
        if (fifo_rd_idx == fifo_wr_cnt && !m_valid && !dut.infl_q) done = 1'b1;
      end
      checkOutput("wrap_done", 32'(done), 1);
      checkOutput("wrap_xfer", 32'(XferCnt), 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
